exec_stage: RTL and testbench
=============================

EXEC_STAGE -- requirements
Module: exec_stage

Interface
REQ-001 clk  input  1  system clock; all state updates on rising edge.
REQ-002 rst_n  input  1  synchronous active-low reset, sampled on rising clk.
REQ-003 in_valid  input  1  upstream presents an instruction this cycle.
REQ-004 in_ready  output  1  stage accepts an instruction this cycle; transfer when in_valid && in_ready.
REQ-005 RegWrite  input  1  write-enable from the control decoder.
REQ-006 ALUCntl  input  4  ALU operation code from the control decoder.
REQ-007 rs_data  input  32  operand A.
REQ-008 rt_data  input  32  operand B.
REQ-009 rd_addr  input  5  destination register index.
REQ-010 out_valid  output  1  result presented downstream.
REQ-011 out_ready  input  1  downstream accepts; transfer when out_valid && out_ready.
REQ-012 out_result  output  32  ALU result.
REQ-013 out_rd  output  5  destination index carried with the result.
REQ-014 out_regwrite  output  1  final write-enable for register file.
REQ-015 out_ovf  output  1  signed overflow on add (1010) or sub (1110).
REQ-016 out_zero  output  1  out_result == 0.
REQ-017 retired  output  16  count of instructions accepted downstream, saturating.

Function
REQ-018 Two register stages, S1 (operands/control latched) and S2 (result latched); latency from input transfer to out_valid is 2 cycles when not stalled.
REQ-019 S1 advances into S2 when S1 valid and (S2 empty or S2 transferring this cycle); in_ready = !S1_valid || S1 advancing (combinational, no dependency on in_valid).
REQ-020 Full throughput: with out_ready held 1, one instruction accepted and one retired per cycle.
REQ-021 Stall: S2 holds all outputs stable while out_valid && !out_ready; S1 holds when it cannot advance; no instruction dropped or duplicated.
REQ-022 Operations: 1010 add, 0010 addu, 1110 sub, 0110 subu, 0000 and, 0001 or, 0011 xor, 1100 nor, 0101 slt (signed, result 0/1), 1111 sltu (unsigned, result 0/1); all 32-bit, wrap modulo 2^32.
REQ-023 Any other ALUCntl: out_result = 0, out_regwrite = 0, out_ovf = 0.
REQ-024 out_ovf = 1 only for 1010/1110 when operand signs produce a result of incorrect sign; addu/subu never flag.
REQ-025 out_regwrite = RegWrite && !out_ovf && (rd_addr != 0) && ALUCntl legal.
REQ-026 out_result on overflow is still the wrapped sum/difference.
REQ-027 retired increments by 1 on each output transfer; holds at 16'hFFFF once reached.
REQ-028 Input transfer and output transfer in the same cycle are both honoured.

Reset
REQ-029 While rst_n = 0 at a rising edge: S1 and S2 emptied, out_valid = 0, out_result = 0, out_rd = 0, out_regwrite = 0, out_ovf = 0, out_zero = 0, retired = 0.
REQ-030 in_ready = 1 in the first cycle after reset release.
REQ-031 Reset asserted mid-operation discards in-flight instructions; none retired and retired not incremented in that cycle.

Verification
REQ-032 Reset then add 1010, rs=7, rt=5, rd=3, RegWrite=1, out_ready=1 -> two cycles later out_valid=1, out_result=12, out_rd=3, out_regwrite=1, out_ovf=0, retired=1.
REQ-033 add 1010, rs=32'h7FFFFFFF, rt=1 -> out_result=32'h80000000, out_ovf=1, out_regwrite=0; same with addu 0010 -> out_ovf=0, out_regwrite=1.
REQ-034 slt 0101 rs=32'hFFFFFFFF, rt=1 -> out_result=1; sltu 1111 same operands -> out_result=0, out_zero=1.
REQ-035 Back-to-back 4 instructions with out_ready=0 for cycles 3-5 -> in_ready drops when S1 and S2 both full, outputs stable during stall, all 4 retire in order, retired=4.
REQ-036 RegWrite=1, rd=0, subu 0110 rs=3 rt=3 -> out_result=0, out_zero=1, out_regwrite=0; ALUCntl=0100 -> out_result=0, out_regwrite=0.
REQ-037 rst_n pulsed low with S1 and S2 full -> next cycle out_valid=0, retired=0, in_ready=1.

Source files
------------

// File: rtl/exec_stage_if.sv
// Bundle of the execute-stage upstream/downstream handshake and result signals.
// Both sides use valid/ready: a beat transfers on a rising edge where valid && ready; valid must not wait on ready.
interface exec_stage_if;
    logic        in_valid;
    logic        in_ready;
    logic        RegWrite;
    logic [3:0]  ALUCntl;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [4:0]  rd_addr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_rd;
    logic        out_regwrite;
    logic        out_ovf;
    logic        out_zero;
    logic [15:0] retired;

    modport master (
        output in_valid, RegWrite, ALUCntl, rs_data, rt_data, rd_addr, out_ready,
        input  in_ready, out_valid, out_result, out_rd, out_regwrite, out_ovf, out_zero, retired
    );

    modport slave (
        input  in_valid, RegWrite, ALUCntl, rs_data, rt_data, rd_addr, out_ready,
        output in_ready, out_valid, out_result, out_rd, out_regwrite, out_ovf, out_zero, retired
    );
endinterface

// File: rtl/exec_stage.sv
// Two-stage ALU execute pipeline: S1 latches operands/control, S2 latches the result.
// Includes overflow and zero flags, write-enable qualification and a saturating retire counter.
module exec_stage (
    input  logic         clk,
    input  logic         rst_n,
    exec_stage_if.slave  bus
);
    logic        r_s1_valid;
    logic        r_s1_regwrite;
    logic [3:0]  r_s1_alucntl;
    logic [31:0] r_s1_rs;
    logic [31:0] r_s1_rt;
    logic [4:0]  r_s1_rd;

    logic        r_s2_valid;
    logic [31:0] r_out_result;
    logic [4:0]  r_out_rd;
    logic        r_out_regwrite;
    logic        r_out_ovf;
    logic        r_out_zero;
    logic [15:0] r_retired;

    logic        w_out_xfer;
    logic        w_s1_adv;
    logic        w_in_ready;
    logic        w_in_xfer;
    logic [31:0] w_sum;
    logic [31:0] w_diff;
    logic [31:0] w_alu_res;
    logic        w_ovf;
    logic        w_legal;
    logic        w_regwrite;

    assign w_out_xfer = r_s2_valid && bus.out_ready;
    assign w_s1_adv   = r_s1_valid && (!r_s2_valid || w_out_xfer);
    assign w_in_ready = !r_s1_valid || w_s1_adv;
    assign w_in_xfer  = bus.in_valid && w_in_ready;

    assign w_sum  = r_s1_rs + r_s1_rt;
    assign w_diff = r_s1_rs - r_s1_rt;

    always_comb begin
        w_alu_res = 32'd0;
        w_ovf     = 1'b0;
        w_legal   = 1'b1;
        case (r_s1_alucntl)
            4'b1010: begin
                w_alu_res = w_sum;
                // Signed overflow: like-signed operands giving an opposite-signed sum.
                w_ovf = (r_s1_rs[31] == r_s1_rt[31]) && (w_sum[31] != r_s1_rs[31]);
            end
            4'b0010: w_alu_res = w_sum;
            4'b1110: begin
                w_alu_res = w_diff;
                w_ovf = (r_s1_rs[31] != r_s1_rt[31]) && (w_diff[31] != r_s1_rs[31]);
            end
            4'b0110: w_alu_res = w_diff;
            4'b0000: w_alu_res = r_s1_rs & r_s1_rt;
            4'b0001: w_alu_res = r_s1_rs | r_s1_rt;
            4'b0011: w_alu_res = r_s1_rs ^ r_s1_rt;
            4'b1100: w_alu_res = ~(r_s1_rs | r_s1_rt);
            4'b0101: w_alu_res = {31'd0, $signed(r_s1_rs) < $signed(r_s1_rt)};
            4'b1111: w_alu_res = {31'd0, r_s1_rs < r_s1_rt};
            default: w_legal = 1'b0;
        endcase
    end

    assign w_regwrite = r_s1_regwrite && !w_ovf && (r_s1_rd != 5'd0) && w_legal;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_valid     <= 1'b0;
            r_s1_regwrite  <= 1'b0;
            r_s1_alucntl   <= 4'd0;
            r_s1_rs        <= 32'd0;
            r_s1_rt        <= 32'd0;
            r_s1_rd        <= 5'd0;
            r_s2_valid     <= 1'b0;
            r_out_result   <= 32'd0;
            r_out_rd       <= 5'd0;
            r_out_regwrite <= 1'b0;
            r_out_ovf      <= 1'b0;
            r_out_zero     <= 1'b0;
            r_retired      <= 16'd0;
        end else begin
            // A new instruction may enter S1 in the same cycle its previous occupant moves on.
            if (w_in_xfer) begin
                r_s1_valid    <= 1'b1;
                r_s1_regwrite <= bus.RegWrite;
                r_s1_alucntl  <= bus.ALUCntl;
                r_s1_rs       <= bus.rs_data;
                r_s1_rt       <= bus.rt_data;
                r_s1_rd       <= bus.rd_addr;
            end else if (w_s1_adv) begin
                r_s1_valid <= 1'b0;
            end

            if (w_s1_adv) begin
                r_s2_valid     <= 1'b1;
                r_out_result   <= w_alu_res;
                r_out_rd       <= r_s1_rd;
                r_out_regwrite <= w_regwrite;
                r_out_ovf      <= w_ovf;
                r_out_zero     <= (w_alu_res == 32'd0);
            end else if (w_out_xfer) begin
                r_s2_valid <= 1'b0;
            end

            if (w_out_xfer && (r_retired != 16'hFFFF)) begin
                r_retired <= r_retired + 16'd1;
            end
        end
    end

    assign bus.in_ready     = w_in_ready;
    assign bus.out_valid    = r_s2_valid;
    assign bus.out_result   = r_out_result;
    assign bus.out_rd       = r_out_rd;
    assign bus.out_regwrite = r_out_regwrite;
    assign bus.out_ovf      = r_out_ovf;
    assign bus.out_zero     = r_out_zero;
    assign bus.retired      = r_retired;
endmodule

// File: tb/tb_exec_stage.sv
// Bench for exec_stage: a queue-based pipeline model checked at every negedge,
// plus directed scenarios with hand-computed literal expectations.
module tb_exec_stage;
  logic clk;
  logic rst_n;
  exec_stage_if bus();

  exec_stage u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] result;
    logic [4:0]  rd;
    logic        rw;
    logic        ovf;
    logic        zero;
    int          age;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] m_retired;
  bit          live;
  bit          just_reset;
  bit          saw_ready_low;
  int          n_cmp;
  int          n_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  // Result rules evaluated with 64-bit arithmetic; overflow means the exact value does not fit in 32 signed bits.
  function automatic exp_t model_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                     input logic rw, input logic [4:0] rd);
    exp_t   e;
    longint sa, sb, full;
    logic [63:0] ua, ub;
    logic   legal;
    logic [31:0] low;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    legal = 1'b1;
    e.ovf = 1'b0;
    full = 0;
    case (op)
      4'b1010: full = sa + sb;
      4'b0010: full = sa + sb;
      4'b1110: full = sa - sb;
      4'b0110: full = sa - sb;
      4'b0000: full = longint'({32'd0, a & b});
      4'b0001: full = longint'({32'd0, a | b});
      4'b0011: full = longint'({32'd0, a ^ b});
      4'b1100: full = longint'({32'd0, ~(a | b)});
      4'b0101: full = (sa < sb) ? 1 : 0;
      4'b1111: full = (ua < ub) ? 1 : 0;
      default: legal = 1'b0;
    endcase
    low = full[31:0];
    if (op == 4'b1010 || op == 4'b1110) e.ovf = (full != longint'($signed(low)));
    e.result = low;
    e.zero   = (low == 32'd0);
    e.rd     = rd;
    e.rw     = rw && !e.ovf && (rd != 5'd0) && legal;
    e.age    = 0;
    return e;
  endfunction

  // Compare process: outputs are stable between edges; inputs for the next edge are already driven.
  always @(negedge clk) begin : compare_proc
    bit   exp_ov, exp_ir, ox, ix;
    exp_t e;
    exp_ov = (exp_q.size() > 0) && (exp_q[0].age >= 2);
    exp_ir = (exp_q.size() < 2) || bus.out_ready;
    if (live) begin
      chk("out_valid", {31'd0, bus.out_valid}, {31'd0, exp_ov});
      chk("in_ready", {31'd0, bus.in_ready}, {31'd0, exp_ir});
      chk("retired", {16'd0, bus.retired}, {16'd0, m_retired});
      if (!bus.in_ready) saw_ready_low = 1'b1;
      if (exp_ov) begin
        chk("out_result", bus.out_result, exp_q[0].result);
        chk("out_rd", {27'd0, bus.out_rd}, {27'd0, exp_q[0].rd});
        chk("out_regwrite", {31'd0, bus.out_regwrite}, {31'd0, exp_q[0].rw});
        chk("out_ovf", {31'd0, bus.out_ovf}, {31'd0, exp_q[0].ovf});
        chk("out_zero", {31'd0, bus.out_zero}, {31'd0, exp_q[0].zero});
      end
      if (just_reset) begin
        chk("rst_result", bus.out_result, 32'd0);
        chk("rst_rd", {27'd0, bus.out_rd}, 32'd0);
        chk("rst_flags", {29'd0, bus.out_regwrite, bus.out_ovf, bus.out_zero}, 32'd0);
      end
    end
    if (!rst_n) begin
      exp_q.delete();
      m_retired  = 16'd0;
      live       = 1'b1;
      just_reset = 1'b1;
    end else if (live) begin
      just_reset = 1'b0;
      ox = exp_ov && bus.out_ready;
      ix = bus.in_valid && exp_ir;
      if (ox) begin
        void'(exp_q.pop_front());
        if (m_retired != 16'hFFFF) m_retired = m_retired + 16'd1;
      end
      foreach (exp_q[i]) exp_q[i].age++;
      if (ix) begin
        e = model_alu(bus.ALUCntl, bus.rs_data, bus.rt_data, bus.RegWrite, bus.rd_addr);
        e.age = 1;
        exp_q.push_back(e);
      end
    end
  end

  task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] rd, input logic rw);
    bit rdy;
    int budget;
    bus.in_valid = 1'b1;
    bus.ALUCntl  = op;
    bus.rs_data  = a;
    bus.rt_data  = b;
    bus.rd_addr  = rd;
    bus.RegWrite = rw;
    budget = 0;
    do begin
      @(negedge clk);
      rdy = bus.in_ready;
      @(posedge clk);
      #1;
      budget++;
    end while (!rdy && budget < 50);
    if (!rdy) chk("send_timeout", 32'd0, 32'd1);
    bus.in_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    while (exp_q.size() != 0 && budget < 100) begin
      @(posedge clk);
      #1;
      budget++;
    end
    if (exp_q.size() != 0) chk("drain_timeout", exp_q.size(), 32'd0);
  endtask

  initial begin
    exp_t e;
    rst_n = 1'b0;
    live = 1'b0; just_reset = 1'b0; saw_ready_low = 1'b0;
    m_retired = 16'd0; n_cmp = 0; n_err = 0;
    bus.in_valid = 1'b0; bus.RegWrite = 1'b0; bus.ALUCntl = 4'd0;
    bus.rs_data = 32'd0; bus.rt_data = 32'd0; bus.rd_addr = 5'd0; bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Literal pins on the model.
    e = model_alu(4'b1010, 32'd7, 32'd5, 1'b1, 5'd3);
    chk("pin_add", e.result, 32'd12);
    e = model_alu(4'b1010, 32'h7FFFFFFF, 32'd1, 1'b1, 5'd4);
    chk("pin_add_ovf", {e.result[31:1], e.ovf, e.rw}, {31'h40000000, 1'b1, 1'b0});
    e = model_alu(4'b0010, 32'h7FFFFFFF, 32'd1, 1'b1, 5'd4);
    chk("pin_addu", {30'd0, e.ovf, e.rw}, 32'd1);
    e = model_alu(4'b0101, 32'hFFFFFFFF, 32'd1, 1'b1, 5'd4);
    chk("pin_slt", e.result, 32'd1);
    e = model_alu(4'b1111, 32'hFFFFFFFF, 32'd1, 1'b1, 5'd4);
    chk("pin_sltu", {e.result[30:0], e.zero}, 32'd1);
    e = model_alu(4'b0110, 32'd3, 32'd3, 1'b1, 5'd0);
    chk("pin_subu_rd0", {e.result[29:0], e.zero, e.rw}, 32'd2);
    e = model_alu(4'b0100, 32'd9, 32'd9, 1'b1, 5'd2);
    chk("pin_illegal", {e.result[30:0], e.rw}, 32'd0);

    // First cycle after reset release: ready, empty.
    @(negedge clk);
    chk("lit_ready_after_rst", {31'd0, bus.in_ready}, 32'd1);
    @(posedge clk); #1;

    // Two-cycle latency for add 7+5.
    send(4'b1010, 32'd7, 32'd5, 5'd3, 1'b1);
    @(negedge clk);
    chk("lit_lat_s1", {31'd0, bus.out_valid}, 32'd0);
    @(negedge clk);
    chk("lit_lat_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("lit_add_result", bus.out_result, 32'd12);
    chk("lit_add_rd_rw", {26'd0, bus.out_rd, bus.out_regwrite}, {26'd0, 5'd3, 1'b1});
    @(negedge clk);
    chk("lit_retired_1", {16'd0, bus.retired}, 32'd1);
    @(posedge clk); #1;

    // Back-to-back operation mix at full throughput.
    send(4'b1010, 32'h7FFFFFFF, 32'd1, 5'd4, 1'b1);
    send(4'b0010, 32'h7FFFFFFF, 32'd1, 5'd4, 1'b1);
    send(4'b0101, 32'hFFFFFFFF, 32'd1, 5'd5, 1'b1);
    send(4'b1111, 32'hFFFFFFFF, 32'd1, 5'd6, 1'b1);
    send(4'b0110, 32'd3, 32'd3, 5'd0, 1'b1);
    send(4'b0100, 32'd9, 32'd9, 5'd7, 1'b1);
    send(4'b1110, 32'h80000000, 32'd1, 5'd8, 1'b1);
    send(4'b1110, 32'd5, 32'd9, 5'd9, 1'b1);
    send(4'b0110, 32'd0, 32'd1, 5'd10, 1'b1);
    send(4'b0000, 32'hF0F0A5A5, 32'hFF00FF00, 5'd11, 1'b1);
    send(4'b0001, 32'hF0F0A5A5, 32'h0F000000, 5'd12, 1'b0);
    send(4'b0011, 32'hFFFF0000, 32'hFF00FF00, 5'd13, 1'b1);
    send(4'b1100, 32'h00000000, 32'h0000FFFF, 5'd14, 1'b1);
    send(4'b0101, 32'd1, 32'hFFFFFFFF, 5'd15, 1'b1);
    send(4'b1010, 32'h80000000, 32'h80000000, 5'd16, 1'b1);
    send(4'b1111, 32'd1, 32'hFFFFFFFF, 5'd31, 1'b1);
    drain();

    // Reset with both stages full while an output transfer is offered.
    bus.out_ready = 1'b0;
    send(4'b0010, 32'd1, 32'd2, 5'd1, 1'b1);
    send(4'b0010, 32'd3, 32'd4, 5'd2, 1'b1);
    @(negedge clk);
    chk("lit_both_full", {30'd0, bus.out_valid, bus.in_ready}, 32'd2);
    @(posedge clk); #1;
    rst_n = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("lit_rst_mid", {14'd0, bus.retired, bus.out_valid, bus.in_ready}, 32'd1);
    @(posedge clk); #1;

    // Four back-to-back with a three-cycle downstream stall.
    do_reset();
    saw_ready_low = 1'b0;
    fork
      begin
        send(4'b0010, 32'd10, 32'd1, 5'd1, 1'b1);
        send(4'b0010, 32'd20, 32'd2, 5'd2, 1'b1);
        send(4'b0010, 32'd30, 32'd3, 5'd3, 1'b1);
        send(4'b0010, 32'd40, 32'd4, 5'd4, 1'b1);
      end
      begin
        repeat (3) @(posedge clk);
        #1 bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 bus.out_ready = 1'b1;
      end
    join
    drain();
    @(negedge clk);
    chk("lit_stall_ready_low", {31'd0, saw_ready_low}, 32'd1);
    chk("lit_retired_4", {16'd0, bus.retired}, 32'd4);
    @(posedge clk); #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
endmodule
